// File: rtl/i2cs_byte_if.sv
// Pad-side and byte-side signals of the I2C target byte engine.
// The slave modport is the engine's view; master is the pad/host side driving it.
interface i2cs_byte_if;
    logic       i2c_scl_i;
    logic       i2c_sda_i;
    logic       i2c_sda_o;
    logic       i2c_sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    modport slave (
        input  i2c_scl_i,
        input  i2c_sda_i,
        input  tx_data,
        output i2c_sda_o,
        output i2c_sda_oe,
        output rx_data,
        output rx_valid,
        output tx_req,
        output start_det,
        output stop_det,
        output busy
    );

    modport master (
        output i2c_scl_i,
        output i2c_sda_i,
        output tx_data,
        input  i2c_sda_o,
        input  i2c_sda_oe,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        input  start_det,
        input  stop_det,
        input  busy
    );
endinterface

// File: rtl/i2cs_byte.sv
// I2C target byte engine: oversampled SCL/SDA, START/STOP detection, 7-bit
// address match, write-byte ACK and read-byte shift-out. No clock stretching.
module i2cs_byte #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic   clk,
    input  logic   rst,
    i2cs_byte_if.slave bus
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;

    // Line index 0 = SCL, 1 = SDA.
    logic [1:0] pad_in;
    logic [1:0] line_s;
    logic [1:0] line_rise;
    logic [1:0] line_fall;

    assign pad_in = {bus.i2c_sda_i, bus.i2c_scl_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_q;
            logic s2_q;
            logic dly_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_q  <= 1'b1;
                    s2_q  <= 1'b1;
                    dly_q <= 1'b1;
                end else begin
                    s1_q  <= pad_in[gi];
                    s2_q  <= s1_q;
                    dly_q <= s2_q;
                end
            end

            assign line_s[gi]    = s2_q;
            assign line_rise[gi] = s2_q & ~dly_q;
            assign line_fall[gi] = ~s2_q & dly_q;
        end
    endgenerate

    // Edges are masked until the pipeline has refilled after reset, so a low
    // line at release cannot masquerade as a START or bus edge.
    logic [1:0] settle_q;
    logic       armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= 2'd0;
        end else if (settle_q != 2'd3) begin
            settle_q <= settle_q + 2'd1;
        end
    end

    assign armed = (settle_q == 2'd3);

    logic scl_rise;
    logic scl_fall;
    logic sda_s;
    logic start_ev;
    logic stop_ev;

    assign scl_rise = armed & line_rise[0];
    assign scl_fall = armed & line_fall[0];
    assign sda_s    = line_s[1];
    assign start_ev = armed & line_fall[1] & line_s[0];
    assign stop_ev  = armed & line_rise[1] & line_s[0];

    logic [2:0] state_q,     state_d;
    logic [3:0] bitcnt_q,    bitcnt_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [6:0] txreg_q,     txreg_d;
    logic       rw_q,        rw_d;
    logic       ack_q,       ack_d;
    logic       sda_oe_q,    sda_oe_d;
    logic       busy_q,      busy_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_valid_q,  rx_valid_d;
    logic       tx_req_q,    tx_req_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q,  stop_det_d;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        txreg_d     = txreg_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;

        if (start_ev) begin
            state_d     = ST_ADDR;
            bitcnt_d    = 4'd0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            start_det_d = 1'b1;
        end else if (stop_ev) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR, ST_WRITE: begin
                    if (scl_rise) begin
                        shreg_d  = {shreg_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        if (state_q == ST_WRITE) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            state_d    = ST_WRITE_ACK;
                        end else if (shreg_q[7:1] == SLV_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shreg_q[0];
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw_q) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        if (rw_q) begin
                            txreg_d  = bus.tx_data[6:0];
                            sda_oe_d = ~bus.tx_data[7];
                            state_d  = ST_READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WRITE;
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 4'd0;
                        state_d  = ST_WRITE;
                    end
                end
                ST_READ: begin
                    // Bit 7 went out on entry; each fall presents the next bit.
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_READ_ACK;
                        end else begin
                            sda_oe_d = ~txreg_q[6];
                            txreg_d  = {txreg_q[5:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        ack_d    = sda_s;
                        tx_req_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (!ack_q) begin
                            txreg_d  = bus.tx_data[6:0];
                            sda_oe_d = ~bus.tx_data[7];
                            bitcnt_d = 4'd0;
                            state_d  = ST_READ;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 4'd0;
            shreg_q     <= 8'd0;
            txreg_q     <= 7'd0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            txreg_q     <= txreg_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign bus.i2c_sda_o  = 1'b0;
    assign bus.i2c_sda_oe = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.start_det  = start_det_q;
    assign bus.stop_det   = stop_det_q;
    assign bus.busy       = busy_q;
endmodule
